// File: rtl/mod_counter.sv
// Modulo up/down counter with load, wrap/saturate, tc pulse and sticky rollover flag.
// Optional prescaler enabled by defining MOD_COUNTER_PRESCALE_EN.
//
// Ports:
//   clk             clock, all state updates on posedge
//   rst_n           synchronous reset, active low
//   en              count enable
//   up              direction: 1 = increment, 0 = decrement
//   sat_mode        1 = saturate at boundary, 0 = wrap
//   load            parallel load strobe (beats en)
//   load_val        value to load, clamped to MOD_MAX
//   clr_flag        clear rollover_sticky
//   q               current count (registered)
//   tc              terminal-count pulse, one cycle after a boundary step
//   rollover_sticky boundary event seen since last clear
//
// Parameters: WIDTH, MOD_MAX (highest count), PRESCALE (enabled cycles
// per step, only when MOD_COUNTER_PRESCALE_EN is defined).
module mod_counter #(
   parameter int WIDTH    = 3,
   parameter int MOD_MAX  = (1 << WIDTH) - 1,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             up,
   input  logic             sat_mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             clr_flag,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             rollover_sticky
);

   localparam logic [WIDTH-1:0] MAX = MOD_MAX[WIDTH-1:0];

   logic             tick;
   logic             step;
   logic             at_bound;
   logic             evt;
   logic [WIDTH-1:0] q_step;
   logic [WIDTH-1:0] q_load;

`ifdef MOD_COUNTER_PRESCALE_EN
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre;

   assign tick = en && (pre == PRE_LAST);

   // Prescaler only advances on enabled cycles, so en=0 keeps its phase.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pre <= '0;
      end else if (load) begin
         pre <= '0;
      end else if (en) begin
         if (pre == PRE_LAST) pre <= '0;
         else                 pre <= pre + 1'b1;
      end
   end
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      step     = en & tick;
      at_bound = up ? (q == MAX) : (q == '0);
      evt      = step & at_bound;
      q_load   = (load_val > MAX) ? MAX : load_val;
      q_step   = q;
      if (up) begin
         if (at_bound) q_step = sat_mode ? MAX : '0;
         else          q_step = q + 1'b1;
      end else begin
         if (at_bound) q_step = sat_mode ? '0 : MAX;
         else          q_step = q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q               <= '0;
         tc              <= 1'b0;
         rollover_sticky <= 1'b0;
      end else if (load) begin
         q               <= q_load;
         tc              <= 1'b0;
         rollover_sticky <= rollover_sticky & ~clr_flag;
      end else begin
         if (step) q <= q_step;
         tc <= evt;
         // A new event wins over a clear in the same cycle.
         rollover_sticky <= evt | (rollover_sticky & ~clr_flag);
      end
   end

endmodule

// File: tb/tb_mod_counter.sv
// Randomized and directed bench for mod_counter (WIDTH=3, MOD_MAX=5).
// Reference model works on plain integers from the behavioural rules.
module tb_mod_counter;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       up;
   logic       sat_mode;
   logic       load;
   logic [2:0] load_val;
   logic       clr_flag;
   logic [2:0] q;
   logic       tc;
   logic       rollover_sticky;

   always #5 clk = ~clk;

   mod_counter #(
      .WIDTH(3),
      .MOD_MAX(5),
      .PRESCALE(4)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .en(en),
      .up(up),
      .sat_mode(sat_mode),
      .load(load),
      .load_val(load_val),
      .clr_flag(clr_flag),
      .q(q),
      .tc(tc),
      .rollover_sticky(rollover_sticky)
   );

   int n_chk  = 0;
   int n_pass = 0;

   int m_q   = 0;
   int m_tc  = 0;
   int m_st  = 0;
   int m_pre = 0;

   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic model_step();
      int lim;
      int tk;
      int ev;
      lim = 5;
      ev  = 0;
      if (!rst_n) begin
         m_q = 0; m_tc = 0; m_st = 0; m_pre = 0;
      end else if (load) begin
         m_q   = (int'(load_val) > lim) ? lim : int'(load_val);
         m_tc  = 0;
         m_pre = 0;
         if (clr_flag) m_st = 0;
      end else begin
`ifdef MOD_COUNTER_PRESCALE_EN
         tk = (en && m_pre == 3) ? 1 : 0;
         if (en) m_pre = (m_pre + 1) % 4;
`else
         tk = 1;
`endif
         if (en && tk == 1) begin
            if (up) begin
               if (m_q == lim) begin ev = 1; m_q = sat_mode ? lim : 0; end
               else m_q = m_q + 1;
            end else begin
               if (m_q == 0) begin ev = 1; m_q = sat_mode ? 0 : lim; end
               else m_q = m_q - 1;
            end
         end
         m_tc = ev;
         if (ev == 1)     m_st = 1;
         else if (clr_flag) m_st = 0;
      end
   endtask

   task automatic cyc(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check({tag, ".q"},  int'(q), m_q);
      check({tag, ".tc"}, int'(tc), m_tc);
      check({tag, ".st"}, int'(rollover_sticky), m_st);
   endtask

   task automatic idle();
      rst_n = 1; en = 0; up = 1; sat_mode = 0;
      load = 0; load_val = 0; clr_flag = 0;
   endtask

   initial begin
      int exp_q[7];
      int exp_tc[7];
      idle();

      // Reset overrides load and en.
      rst_n = 0; load = 1; en = 1; load_val = 3'd7;
      cyc("reset");
      check("reset.q0", int'(q), 0);
      check("reset.tc0", int'(tc), 0);
      check("reset.st0", int'(rollover_sticky), 0);
      idle();

`ifndef MOD_COUNTER_PRESCALE_EN
      // Up wrap from 0.
      exp_q  = '{1, 2, 3, 4, 5, 0, 1};
      exp_tc = '{0, 0, 0, 0, 0, 1, 0};
      en = 1; up = 1; sat_mode = 0;
      for (int i = 0; i < 7; i++) begin
         cyc("upwrap");
         check("upwrap.qc", int'(q), exp_q[i]);
         check("upwrap.tcc", int'(tc), exp_tc[i]);
      end
      check("upwrap.sticky", int'(rollover_sticky), 1);

      // Down saturate after loading 1.
      idle(); load = 1; load_val = 3'd1;
      cyc("dsat.ld");
      idle(); en = 1; up = 0; sat_mode = 1;
      for (int i = 0; i < 4; i++) begin
         cyc("dsat");
         check("dsat.qc", int'(q), 0);
         check("dsat.tcc", int'(tc), (i == 0) ? 0 : 1);
      end

      // Load clamp and priority over en.
      idle(); load = 1; load_val = 3'd7; en = 1; up = 1;
      cyc("ldclamp");
      check("ldclamp.qc", int'(q), 5);
      check("ldclamp.tcc", int'(tc), 0);
      load_val = 3'd3;
      cyc("ld3");
      check("ld3.qc", int'(q), 3);

      // Sticky clear, then clear racing a wrap.
      idle(); clr_flag = 1;
      cyc("clr");
      check("clr.st0", int'(rollover_sticky), 0);
      idle(); load = 1; load_val = 3'd5;
      cyc("clr.ld");
      idle(); en = 1; up = 1; clr_flag = 1;
      cyc("clrwrap");
      check("clrwrap.q0", int'(q), 0);
      check("clrwrap.st1", int'(rollover_sticky), 1);
`else
      // Prescaled count: 12 enabled cycles give 3 steps.
      en = 1; up = 1;
      for (int i = 0; i < 12; i++) cyc("pre");
      check("pre.q3", int'(q), 3);
      cyc("pre.a");
      en = 0;
      cyc("pre.hold");
      cyc("pre.hold");
      check("pre.frz", int'(q), 3);
      en = 1;
      cyc("pre.b");
      cyc("pre.c");
      check("pre.q3b", int'(q), 3);
      cyc("pre.d");
      check("pre.q4", int'(q), 4);
`endif

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst_n    = ($urandom_range(99) >= 2);
         en       = ($urandom_range(99) < 70);
         up       = $urandom_range(1);
         sat_mode = ($urandom_range(99) < 30);
         load     = ($urandom_range(99) < 8);
         load_val = 3'($urandom_range(7));
         clr_flag = ($urandom_range(99) < 10);
         cyc("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
